cpu_ctrl_fsm: RTL

- Parametrised multi-cycle control unit for the Simple RISC Machine.
- Holds PC, IR and the data-address register, sequences fetch, decode and execute, and drives all datapath control lines.
- New over the previous generation: width parameters, a memory wait-state handshake (mem_ready), Moore-decoded control outputs, and optional conditional branches.
- Sits between the instruction/data memory and the datapath inside cpu_top.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/cpu_ctrl_fsm_instr_decoder.sv | 31 +++
 rtl/ld_reg.sv | 17 +
 rtl/cpu_ctrl_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple RISC Machine control unit.
// CPU_CTRL_BRANCH_EN adds the BRANCH state to the state enum.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE, S_MOVI, S_GETA, S_GETB, S_EXEC, S_WB,
    S_LD_ADDR, S_LD_MEM, S_LD_WB,
    S_ST_ADDR, S_ST_RD, S_ST_PASS, S_ST_LOADC, S_ST_WRITE,
    S_HALT
`ifdef CPU_CTRL_BRANCH_EN
    , S_BRANCH
`endif
  } state_t;

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_LDR    = 3'b011;
  localparam logic [2:0] OPC_STR    = 3'b100;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  localparam logic [1:0] OP_MOVSH = 2'b00;
  localparam logic [1:0] OP_MOVI  = 2'b10;

  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] NSEL_RN = 2'd0;
  localparam logic [1:0] NSEL_RD = 2'd1;
  localparam logic [1:0] NSEL_RM = 2'd2;

  // nvz = {N,V,Z}
  function automatic logic cond_taken(input logic [2:0] cond, input logic [2:0] nvz);
    logic t;
    case (cond)
      COND_B:   t = 1'b1;
      COND_BEQ: t = nvz[0];
      COND_BNE: t = !nvz[0];
      COND_BLT: t = nvz[2] != nvz[1];
      COND_BLE: t = (nvz[2] != nvz[1]) || nvz[0];
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_instr_decoder.sv
// Instruction field extraction, sign extension and register-index mux.
module instr_decoder #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [1:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        regnum
);
  import cpu_pkg::*;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign shift  = ir[4:3];
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  always_comb begin
    regnum = ir[10:8];
    case (nsel)
      NSEL_RD: regnum = ir[7:5];
      NSEL_RM: regnum = ir[2:0];
      default: regnum = ir[10:8];
    endcase
  end

endmodule

// File: rtl/ld_reg.sv
// Load-enable register with synchronous active-high clear.
module ld_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: PC/IR/data-address registers, fetch-decode-execute sequencing.
// Define CPU_CTRL_BRANCH_EN to add conditional branches (opcode 001).
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] dp_out,
  input  logic [2:0]        flags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_cmd,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   ir;
  logic [ADDR_W-1:0]   dar;
  logic [ADDR_W-1:0]   pc_d;
  logic                pc_en, ir_en, dar_en, addr_dar;
  logic [1:0]          nsel;
  logic [2:0]          opcode, regnum;
  logic [1:0]          op;
  logic                unused_dp;

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir),
    .nsel   (nsel),
    .opcode (opcode),
    .op     (op),
    .shift  (shift),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .regnum (regnum)
  );

  assign alu_op   = op;
  assign readnum  = regnum;
  assign writenum = regnum;
  assign mem_addr = addr_dar ? dar : pc;

  assign ir_en  = (state == S_IF2) && mem_ready;
  assign dar_en = (state == S_LD_ADDR) || (state == S_ST_ADDR);
  assign unused_dp = ^dp_out[DATA_W-1:ADDR_W];

`ifdef CPU_CTRL_BRANCH_EN
  logic br_take;
  assign br_take = (state == S_BRANCH) && cond_taken(ir[10:8], flags);
  assign pc_en   = (state == S_UPDPC) || br_take;
  // PC was already incremented in UPDPC, so the offset is relative to the next instruction.
  assign pc_d    = br_take ? pc + sximm8[ADDR_W-1:0] : pc + ADDR_W'(1);
`else
  logic unused_flags;
  assign unused_flags = ^flags;
  assign pc_en = (state == S_UPDPC);
  assign pc_d  = pc + ADDR_W'(1);
`endif

  ld_reg #(.W(ADDR_W)) u_pc  (.clk(clk), .reset(reset), .en(pc_en),  .d(pc_d),                   .q(pc));
  ld_reg #(.W(DATA_W)) u_ir  (.clk(clk), .reset(reset), .en(ir_en),  .d(mem_rdata),              .q(ir));
  ld_reg #(.W(ADDR_W)) u_dar (.clk(clk), .reset(reset), .en(dar_en), .d(dp_out[ADDR_W-1:0]),     .q(dar));

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RST:    state_nx = S_IF1;
      S_IF1:    state_nx = S_IF2;
      S_IF2:    state_nx = mem_ready ? S_UPDPC : S_IF2;
      S_UPDPC:  state_nx = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOVI) state_nx = S_MOVI;
        else if (opcode == OPC_HALT)            state_nx = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
        else if (opcode == OPC_BRANCH)          state_nx = S_BRANCH;
`else
        else if (opcode == OPC_BRANCH)          state_nx = S_IF1;
`endif
        else                                    state_nx = S_GETA;
      end
      S_MOVI:   state_nx = S_IF1;
      S_GETA:   state_nx = S_GETB;
      S_GETB: begin
        if (opcode == OPC_ALU || opcode == OPC_LDR || opcode == OPC_STR ||
            (opcode == OPC_MOV && op == OP_MOVSH))
          state_nx = S_EXEC;
        else
          state_nx = S_IF1;
      end
      S_EXEC: begin
        if (opcode == OPC_LDR)      state_nx = S_LD_ADDR;
        else if (opcode == OPC_STR) state_nx = S_ST_ADDR;
        else                        state_nx = S_WB;
      end
      S_WB:       state_nx = S_IF1;
      S_LD_ADDR:  state_nx = S_LD_MEM;
      S_LD_MEM:   state_nx = mem_ready ? S_LD_WB : S_LD_MEM;
      S_LD_WB:    state_nx = S_IF1;
      S_ST_ADDR:  state_nx = S_ST_RD;
      S_ST_RD:    state_nx = S_ST_PASS;
      S_ST_PASS:  state_nx = S_ST_LOADC;
      S_ST_LOADC: state_nx = S_ST_WRITE;
      S_ST_WRITE: state_nx = mem_ready ? S_IF1 : S_ST_WRITE;
      S_HALT:     state_nx = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
      S_BRANCH:   state_nx = S_IF1;
`endif
      default:    state_nx = S_RST;
    endcase
  end

  always_comb begin
    mem_cmd  = MNONE;
    nsel     = NSEL_RN;
    vsel     = VSEL_C;
    addr_dar = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_IF1, S_IF2: mem_cmd = MREAD;
      S_MOVI: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      // ALU result is captured in the same cycle the operands are selected.
      S_EXEC: begin
        loadc = 1'b1;
        loads = (opcode == OPC_ALU);
        if (opcode == OPC_MOV)                           asel = 1'b1;
        else if (opcode == OPC_LDR || opcode == OPC_STR) bsel = 1'b1;
      end
      S_WB: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_LD_MEM: begin
        mem_cmd  = MREAD;
        addr_dar = 1'b1;
      end
      S_LD_WB: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_MDATA;
        write = 1'b1;
      end
      S_ST_RD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_ST_PASS:  asel  = 1'b1;
      S_ST_LOADC: loadc = 1'b1;
      S_ST_WRITE: begin
        mem_cmd  = MWRITE;
        addr_dar = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
